// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares a single-port, byte-wide synchronous RAM between the instruction
//   fetch stage (always 32-bit reads) and the memory stage (8/16/32-bit
//   loads and stores). Each access is split into consecutive byte cycles.
//   Data is assembled or disassembled little-endian.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   if_req/if_addr      fetch request (level) and byte address
//   if_data/if_done     fetched word (registered) and one-cycle done pulse
//   mem_req/mem_wr      load/store request (level); 1 = store
//   mem_len             0 byte, 1 half, 2/3 word
//   mem_addr/mem_wdata  load/store byte address and store data
//   mem_rdata/mem_done  zero-extended load data and one-cycle done pulse
//   ram_a/ram_wr        RAM byte address and write strobe
//   ram_dout/ram_din    byte to RAM / byte from RAM (valid one cycle after
//                       its address)
//   o_dbg_state         current FSM state, for observation only
//
// Handshake: a requester raises req and holds it, with its address and data,
// until it sees its done pulse. Address, length and data are latched at the
// acceptance edge, so later input changes have no effect. The requester must
// drop req by the edge after done; a req still high in IDLE counts as a new
// request. mem_req wins over if_req because the memory-stage instruction is
// older.
// ---------------------------------------------------------------------------
module mem_arbiter #(
   parameter int ADDR_W = 17
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [31:0]       if_addr,
   output logic [31:0]       if_data,
   output logic              if_done,
   input  logic              mem_req,
   input  logic              mem_wr,
   input  logic [1:0]        mem_len,
   input  logic [31:0]       mem_addr,
   input  logic [31:0]       mem_wdata,
   output logic [31:0]       mem_rdata,
   output logic              mem_done,
   output logic [ADDR_W-1:0] ram_a,
   output logic              ram_wr,
   output logic [7:0]        ram_dout,
   input  logic [7:0]        ram_din,
   output logic [1:0]        o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_addr;
   logic [31:0]         r_wdata;
   logic [31:0]         r_buf;
   logic [2:0]          r_nbytes;
   logic [2:0]          r_idx;     // byte cycle index, 0 in cycle 1
   logic                r_is_mem;

   logic [2:0]          w_mem_n;
   logic [2:0]          w_next_idx;
   logic [ADDR_W-1:0]   w_next_a;
   logic                w_more;
   logic [1:0]          w_lane;
   logic [31:0]         w_merged;
   logic [7:0]          w_wbyte;
   logic                w_unused;

   // Upper address bits are deliberately discarded by truncation.
   assign w_unused = ^{if_addr[31:ADDR_W], mem_addr[31:ADDR_W]};

   always_comb begin
      w_mem_n = 3'd4;
      case (mem_len)
         2'd0:    w_mem_n = 3'd1;
         2'd1:    w_mem_n = 3'd2;
         default: w_mem_n = 3'd4;
      endcase
   end

   assign w_next_idx = r_idx + 3'd1;
   // Wraps naturally modulo 2^ADDR_W.
   assign w_next_a   = r_addr + {{(ADDR_W-3){1'b0}}, w_next_idx};
   assign w_more     = (w_next_idx < r_nbytes);
   // RAM read latency is one cycle, so the byte arriving now belongs to the
   // address issued in the previous cycle.
   assign w_lane     = r_idx[1:0] - 2'd1;
   assign w_wbyte    = r_wdata[{w_next_idx[1:0], 3'b000} +: 8];

   always_comb begin
      w_merged = r_buf;
      w_merged[{w_lane, 3'b000} +: 8] = ram_din;
   end

   assign o_dbg_state = r_state;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_buf     <= '0;
         r_nbytes  <= '0;
         r_idx     <= '0;
         r_is_mem  <= 1'b0;
         if_data   <= '0;
         if_done   <= 1'b0;
         mem_rdata <= '0;
         mem_done  <= 1'b0;
         ram_a     <= '0;
         ram_wr    <= 1'b0;
         ram_dout  <= '0;
      end else begin
         if_done  <= 1'b0;
         mem_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_idx <= '0;
               r_buf <= '0;
               if (mem_req) begin
                  r_is_mem <= 1'b1;
                  r_addr   <= mem_addr[ADDR_W-1:0];
                  r_wdata  <= mem_wdata;
                  r_nbytes <= w_mem_n;
                  ram_a    <= mem_addr[ADDR_W-1:0];
                  if (mem_wr) begin
                     r_state  <= S_WRITE;
                     ram_wr   <= 1'b1;
                     ram_dout <= mem_wdata[7:0];
                  end else begin
                     r_state  <= S_READ;
                  end
               end else if (if_req) begin
                  r_is_mem <= 1'b0;
                  r_addr   <= if_addr[ADDR_W-1:0];
                  r_wdata  <= '0;
                  r_nbytes <= 3'd4;
                  ram_a    <= if_addr[ADDR_W-1:0];
                  r_state  <= S_READ;
               end
            end

            S_READ: begin
               r_idx <= w_next_idx;
               if (r_idx != 3'd0) r_buf <= w_merged;
               ram_a <= w_more ? w_next_a : '0;
               // Final byte lands now; publish it with the done pulse.
               if (r_idx == r_nbytes) begin
                  r_state <= S_DONE;
                  if (r_is_mem) begin
                     mem_rdata <= w_merged;
                     mem_done  <= 1'b1;
                  end else begin
                     if_data   <= w_merged;
                     if_done   <= 1'b1;
                  end
               end
            end

            S_WRITE: begin
               r_idx <= w_next_idx;
               if (w_more) begin
                  ram_a    <= w_next_a;
                  ram_dout <= w_wbyte;
               end else begin
                  ram_a    <= '0;
                  ram_wr   <= 1'b0;
                  ram_dout <= '0;
                  r_state  <= S_DONE;
                  mem_done <= 1'b1;
               end
            end

            S_DONE: begin
               r_state <= S_IDLE;
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter with a behavioural byte-wide synchronous
//   RAM. Expected values are hand-computed from the intended timing.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int ADDR_W = 17;

   logic              clk;
   logic              rst;
   logic              if_req;
   logic [31:0]       if_addr;
   logic [31:0]       if_data;
   logic              if_done;
   logic              mem_req;
   logic              mem_wr;
   logic [1:0]        mem_len;
   logic [31:0]       mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              mem_done;
   logic [ADDR_W-1:0] ram_a;
   logic              ram_wr;
   logic [7:0]        ram_dout;
   logic [7:0]        ram_din;
   logic [1:0]        o_dbg_state;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] ram [0:(1<<ADDR_W)-1];

   mem_arbiter #(.ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_data    (if_data),
      .if_done    (if_done),
      .mem_req    (mem_req),
      .mem_wr     (mem_wr),
      .mem_len    (mem_len),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_done   (mem_done),
      .ram_a      (ram_a),
      .ram_wr     (ram_wr),
      .ram_dout   (ram_dout),
      .ram_din    (ram_din),
      .o_dbg_state(o_dbg_state)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read RAM model
   always @(posedge clk) begin
      ram_din <= ram[ram_a];
      if (ram_wr) ram[ram_a] <= ram_dout;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      if_req    = 1'b0;
      if_addr   = '0;
      mem_req   = 1'b0;
      mem_wr    = 1'b0;
      mem_len   = 2'd0;
      mem_addr  = '0;
      mem_wdata = '0;
   endtask

   initial begin
      for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 8'h00;
      ram[17'h00100] = 8'h13;
      ram[17'h1FFFF] = 8'h34;
      ram[17'h00000] = 8'h12;
      ram_din = 8'h00;
      idle_inputs();
      rst = 1'b1;

      // ---------------- reset state ----------------
      step(); step();
      chk("rst_if_data",   if_data,   32'h0);
      chk("rst_mem_rdata", mem_rdata, 32'h0);
      chk("rst_dones",     {30'd0, if_done, mem_done}, 32'h0);
      chk("rst_ram_a",     ram_a,     32'h0);
      chk("rst_ram_wr",    ram_wr,    32'h0);
      chk("rst_ram_dout",  ram_dout,  32'h0);
      chk("rst_state",     o_dbg_state, 32'h0);
      rst = 1'b0;
      step();

      // ---------------- word fetch at 0x100 ----------------
      if_req = 1'b1; if_addr = 32'h0000_0100;
      step(); chk("fetch_c1_a", ram_a, 32'h100); chk("fetch_c1_wr", ram_wr, 32'h0);
      step(); chk("fetch_c2_a", ram_a, 32'h101);
      step(); chk("fetch_c3_a", ram_a, 32'h102);
      step(); chk("fetch_c4_a", ram_a, 32'h103); chk("fetch_c4_done", if_done, 32'h0);
      step(); chk("fetch_c5_a", ram_a, 32'h0);   chk("fetch_c5_done", if_done, 32'h0);
      step(); chk("fetch_c6_done", if_done, 32'h1);
      chk("fetch_c6_data", if_data, 32'h0000_0013);
      chk("fetch_c6_mdone", mem_done, 32'h0);
      if_req = 1'b0;
      step(); chk("fetch_c7_done", if_done, 32'h0); chk("fetch_c7_hold", if_data, 32'h13);
      chk("fetch_c7_state", o_dbg_state, 32'h0);

      // ---------------- word store at 0x20 ----------------
      mem_req = 1'b1; mem_wr = 1'b1; mem_len = 2'd2;
      mem_addr = 32'h0000_0020; mem_wdata = 32'hDEAD_BEEF;
      step(); chk("st_c1", {ram_wr, 7'd0, ram_dout, 15'd0, ram_a}, {1'b1, 7'd0, 8'hEF, 15'd0, 17'h20});
      mem_wdata = 32'h0; mem_addr = 32'h0000_0700;  // must be ignored once latched
      step(); chk("st_c2", {ram_wr, 7'd0, ram_dout, 15'd0, ram_a}, {1'b1, 7'd0, 8'hBE, 15'd0, 17'h21});
      step(); chk("st_c3", {ram_wr, 7'd0, ram_dout, 15'd0, ram_a}, {1'b1, 7'd0, 8'hAD, 15'd0, 17'h22});
      step(); chk("st_c4", {ram_wr, 7'd0, ram_dout, 15'd0, ram_a}, {1'b1, 7'd0, 8'hDE, 15'd0, 17'h23});
      chk("st_c4_done", mem_done, 32'h0);
      step(); chk("st_c5_done", mem_done, 32'h1); chk("st_c5_ifdone", if_done, 32'h0);
      chk("st_c5_wr", ram_wr, 32'h0);
      chk("st_rdata_untouched", mem_rdata, 32'h0);
      idle_inputs();
      step();
      chk("st_ram", {ram[17'h23], ram[17'h22], ram[17'h21], ram[17'h20]}, 32'hDEAD_BEEF);

      // ---------------- byte load at 0x23 ----------------
      mem_req = 1'b1; mem_wr = 1'b0; mem_len = 2'd0; mem_addr = 32'h0000_0023;
      step(); chk("lb_c1_a", ram_a, 32'h23);
      step(); chk("lb_c2_done", mem_done, 32'h0);
      step(); chk("lb_c3_done", mem_done, 32'h1); chk("lb_c3_data", mem_rdata, 32'h0000_00DE);
      idle_inputs();
      step();

      // ---------------- half load at 0x22 ----------------
      mem_req = 1'b1; mem_wr = 1'b0; mem_len = 2'd1; mem_addr = 32'h0000_0022;
      step(); chk("lh_c1_a", ram_a, 32'h22);
      step(); chk("lh_c2_a", ram_a, 32'h23);
      step(); chk("lh_c3_done", mem_done, 32'h0);
      step(); chk("lh_c4_done", mem_done, 32'h1); chk("lh_c4_data", mem_rdata, 32'h0000_DEAD);
      idle_inputs();
      step();
      chk("lh_hold", mem_rdata, 32'h0000_DEAD);

      // ---------------- contention: byte store vs fetch ----------------
      if_req = 1'b1; if_addr = 32'h0000_0100;
      mem_req = 1'b1; mem_wr = 1'b1; mem_len = 2'd0;
      mem_addr = 32'h0000_0040; mem_wdata = 32'h1234_5655;
      step(); chk("ct_c1", {ram_wr, 7'd0, ram_dout, 15'd0, ram_a}, {1'b1, 7'd0, 8'h55, 15'd0, 17'h40});
      step(); chk("ct_c2_mdone", mem_done, 32'h1); chk("ct_c2_ifdone", if_done, 32'h0);
      mem_req = 1'b0;
      step(); chk("ct_c3_idle", o_dbg_state, 32'h0); chk("ct_c3_wr", ram_wr, 32'h0);
      step(); chk("ct_c4_a", ram_a, 32'h100);
      step(); step(); step(); chk("ct_c7_a", ram_a, 32'h103);
      step(); chk("ct_c8_ifdone", if_done, 32'h0);
      step(); chk("ct_c9_ifdone", if_done, 32'h1); chk("ct_c9_data", if_data, 32'h0000_0013);
      chk("ct_c9_mdone", mem_done, 32'h0);
      idle_inputs();
      step();
      chk("ct_ram40", ram[17'h40], 32'h55);
      chk("ct_once", {30'd0, if_done, mem_done}, 32'h0);

      // ---------------- wrap: half load at 0x1FFFF ----------------
      mem_req = 1'b1; mem_wr = 1'b0; mem_len = 2'd1; mem_addr = 32'hFFFF_FFFF;
      step(); chk("wr_c1_a", ram_a, 32'h1FFFF);
      step(); chk("wr_c2_a", ram_a, 32'h00000); chk("wr_c2_state", o_dbg_state, 32'h1);
      step(); chk("wr_c3_done", mem_done, 32'h0);
      step(); chk("wr_c4_done", mem_done, 32'h1); chk("wr_c4_data", mem_rdata, 32'h0000_1234);
      idle_inputs();
      step();

      // ---------------- reset during word store ----------------
      mem_req = 1'b1; mem_wr = 1'b1; mem_len = 2'd2;
      mem_addr = 32'h0000_0060; mem_wdata = 32'hA1B2_C3D4;
      step(); chk("rs_c1", {ram_wr, 7'd0, ram_dout, 15'd0, ram_a}, {1'b1, 7'd0, 8'hD4, 15'd0, 17'h60});
      step(); chk("rs_c2", {ram_wr, 7'd0, ram_dout, 15'd0, ram_a}, {1'b1, 7'd0, 8'hC3, 15'd0, 17'h61});
      rst = 1'b1; idle_inputs();
      step(); chk("rs_c3_wr", ram_wr, 32'h0); chk("rs_c3_a", ram_a, 32'h0);
      chk("rs_c3_done", mem_done, 32'h0); chk("rs_c3_state", o_dbg_state, 32'h0);
      rst = 1'b0;
      step(); chk("rs_c4_done", mem_done, 32'h0); chk("rs_c4_wr", ram_wr, 32'h0);
      chk("rs_ram", {ram[17'h63], ram[17'h62], ram[17'h61], ram[17'h60]}, 32'h0000_C3D4);
      chk("rs_if_data_cleared", if_data, 32'h0);

      // Fetch after reset is served normally.
      if_req = 1'b1; if_addr = 32'h0000_0100;
      step(); chk("rf_c1_a", ram_a, 32'h100);
      step(); step(); step(); step(); chk("rf_c5_done", if_done, 32'h0);
      step(); chk("rf_c6_done", if_done, 32'h1); chk("rf_c6_data", if_data, 32'h0000_0013);
      idle_inputs();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences and shares the single-port, byte-wide main RAM between two requesters: the instruction-fetch stage (word reads) and the memory stage (loads/stores, using the address and store data produced by the execute stage).
- Splits each 8/16/32-bit access into consecutive byte cycles and assembles or disassembles the data little-endian.
- Returns a one-cycle done pulse to whichever requester it served. Pipeline stall logic keys off the request/done pair.

Parameters:
- ADDR_W, 17, RAM byte-address width; requester addresses are truncated to this width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  fetch request, level, held until if_done
- if_addr  in  32  fetch byte address
- if_data  out  32  fetched word, registered
- if_done  out  1  one-cycle pulse, if_data valid
- mem_req  in  1  load/store request, level, held until mem_done
- mem_wr  in  1  1 = store, 0 = load
- mem_len  in  2  0 = byte, 1 = half, 2 = word, 3 = treated as word
- mem_addr  in  32  load/store byte address
- mem_wdata  in  32  store data; low bytes used for byte/half
- mem_rdata  out  32  load data, zero-extended; sign extension belongs to the memory stage
- mem_done  out  1  one-cycle pulse
- ram_a  out  ADDR_W  RAM byte address
- ram_wr  out  1  RAM write strobe
- ram_dout  out  8  byte to RAM
- ram_din  in  8  byte from RAM; valid the cycle after its address is presented (synchronous read)

Behaviour:
- Reset: all outputs 0, FSM in IDLE, byte counter 0, data registers 0.
- FSM states: IDLE, READ, WRITE, DONE.
- Arbitration: sampled at each clock edge while in IDLE.
  - mem_req has priority over if_req, because the memory-stage instruction is older.
  - The winner's address, len and wdata are latched at the acceptance edge. Later changes on the inputs are ignored until done.
  - A fetch is always 4 bytes, read.
- Byte count: n = 1, 2 or 4. Cycle 1 is the first cycle after acceptance.
- READ:
  - Cycle i+1 (i = 0..n-1): ram_a = addr+i.
  - Byte i is captured from ram_din at the end of cycle i+2 into bits [8i+7:8i].
  - Bits above 8n are 0.
  - The DONE state is entered so that done is high in cycle n+2. A word read therefore has done in cycle 6.
- WRITE:
  - Cycle i+1: ram_a = addr+i, ram_wr = 1, ram_dout = wdata[8i+7:8i].
  - done is high in cycle n+1. A word store therefore has done in cycle 5.
- Address arithmetic: addr+i wraps modulo 2^ADDR_W. There is no alignment requirement.
- DONE:
  - Exactly one of if_done/mem_done is high for one cycle.
  - The matching data output is updated in that cycle.
  - Next state is IDLE unconditionally.
  - Requesters must drop req by the following edge. A req still high in IDLE is a new request.
- Outputs outside active byte cycles: ram_wr = 0, ram_a = 0, ram_dout = 0.
- if_data and mem_rdata hold their values until their own next completion. mem_rdata is not updated by stores.
- Simultaneous events: both requests high in IDLE → MEM is served; IF waits, with its req held, and is accepted in the IDLE cycle after mem_done.
- A request arriving while busy waits. No request is ever lost or served twice.
- Reset mid-operation:
  - The next edge returns to IDLE with ram_wr = 0.
  - No done is issued.
  - Bytes already written stay written.

Test Plan:
- Word fetch: RAM[0x100..0x103] = 13,00,00,00, if_req with addr 0x100 → ram_a = 0x100..0x103 in cycles 1-4, if_done only in cycle 6, if_data = 0x00000013.
- Word store: mem_wr = 1, len = 2, addr 0x20, wdata 0xDEADBEEF → writes EF, BE, AD, DE to 0x20..0x23 in cycles 1-4 with ram_wr = 1, mem_done in cycle 5, if_done stays 0.
- Byte load: after the store, len = 0, addr 0x23 → mem_done in cycle 3, mem_rdata = 0x000000DE. Half load at 0x22 → 0x0000DEAD in cycle 4.
- Contention: if_req and mem_req rise in the same cycle → MEM store served first. IF is accepted in the IDLE cycle after mem_done and completes 6 cycles later with correct data.
- Wrap: ADDR_W = 17, half load at 0x1FFFF → ram_a = 0x1FFFF then 0x00000, and the two bytes are assembled in that order.
- Reset during a word store at cycle 2 → ram_wr = 0 from the following cycle, no mem_done, only bytes 0-1 written, and a following fetch is served normally.
